sram_responder: RTL and testbench

- Responder end of the core's instruction-SRAM and data-SRAM interfaces: the memory side that the CPU core drives.
- Holds a word-addressed RAM array with a read-only instruction port and a read/write data port with byte enables.
- Also holds one memory-mapped free-running timer register on the data port.
- Sits beside the CPU core in the SoC top or the simulation bench, replacing a vendor BRAM so the pipeline can be verified end to end.

---
 rtl/sram_responder_if.sv | 42 ++++
 rtl/sram_responder.sv | 103 ++++++++++
 tb/tb_sram_responder.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/sram_responder_if.sv
// -----------------------------------------------------------------------------
// sram_responder_if
// Bundles the instruction-SRAM and data-SRAM bus signals between the CPU core
// (master) and the memory responder (slave).
//   inst_sram_en     : instruction-port access request
//   inst_sram_wen    : instruction-port byte write enables (ignored by slave)
//   inst_sram_addr   : instruction byte address
//   inst_sram_wdata  : instruction write data (unused by slave)
//   inst_sram_rdata  : instruction read data, registered in the slave
//   data_sram_en     : data-port access request
//   data_sram_wen    : data-port byte write enables, bit i -> lane [8i+7:8i]
//   data_sram_addr   : data byte address
//   data_sram_wdata  : data write data
//   data_sram_rdata  : data read data, registered in the slave
// -----------------------------------------------------------------------------
interface sram_responder_if;
   logic        inst_sram_en;
   logic [3:0]  inst_sram_wen;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic [31:0] inst_sram_rdata;

   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;

   modport master (
      output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
      input  inst_sram_rdata,
      output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
      input  data_sram_rdata
   );

   modport slave (
      input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
      output inst_sram_rdata,
      input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
      output data_sram_rdata
   );
endinterface

// File: rtl/sram_responder.sv
// -----------------------------------------------------------------------------
// sram_responder
// Memory-side responder for the core's instruction and data SRAM buses.
// Holds a 2^ADDR_W x 32-bit word array with a read-only instruction port and
// a byte-enabled read/write data port, plus one memory-mapped free-running
// 32-bit timer at TIMER_ADDR on the data port. No handshake; every access is
// accepted in the cycle it is sampled and read data appears one cycle later.
//   clk  : system clock, all state changes on the rising edge
//   rst  : synchronous active-high reset (clears rdata and timer, not RAM)
//   bus  : slave side of sram_responder_if (both SRAM ports)
// -----------------------------------------------------------------------------
module sram_responder #(
   parameter int unsigned ADDR_W     = 14,
   parameter logic [31:0] TIMER_ADDR = 32'hBFAF_E000
) (
   input  logic             clk,
   input  logic             rst,
   sram_responder_if.slave  bus
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [31:0] mem [DEPTH];
   logic [31:0] timer;
   logic [31:0] inst_rdata_q;
   logic [31:0] data_rdata_q;

   logic [ADDR_W-1:0] inst_idx;
   logic [ADDR_W-1:0] data_idx;
   logic              data_timer_sel;
   logic              data_rd;
   logic              data_wr;
   logic [31:0]       timer_merged;

   assign inst_idx       = bus.inst_sram_addr[ADDR_W+1:2];
   assign data_idx       = bus.data_sram_addr[ADDR_W+1:2];
   assign data_timer_sel = (bus.data_sram_addr == TIMER_ADDR);
   assign data_rd        = bus.data_sram_en && (bus.data_sram_wen == 4'b0000);
   assign data_wr        = bus.data_sram_en && (bus.data_sram_wen != 4'b0000);

   // Byte-lane merge of the write data over the current timer value.
   always_comb begin
      timer_merged = timer;
      for (int unsigned i = 0; i < 4; i++) begin
         if (bus.data_sram_wen[i]) begin
            timer_merged[8*i +: 8] = bus.data_sram_wdata[8*i +: 8];
         end
      end
   end

   // RAM array: written only by the data port, never on the timer address,
   // never while in reset. Not reset itself.
   always_ff @(posedge clk) begin
      if (!rst && data_wr && !data_timer_sel) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (bus.data_sram_wen[i]) begin
               mem[data_idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
            end
         end
      end
   end

   // Instruction port: always a read; wen is ignored. Non-blocking reads of
   // mem give read-first behaviour against a same-cycle data write.
   always_ff @(posedge clk) begin
      if (rst) begin
         inst_rdata_q <= '0;
      end else if (bus.inst_sram_en) begin
         inst_rdata_q <= mem[inst_idx];
      end
   end

   // Data port read data: updates only on reads, returns the timer value
   // held before the sampling edge when the timer is addressed.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_rdata_q <= '0;
      end else if (data_rd) begin
         data_rdata_q <= data_timer_sel ? timer : mem[data_idx];
      end
   end

   // Timer: a write replaces the increment for that cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         timer <= '0;
      end else if (data_wr && data_timer_sel) begin
         timer <= timer_merged;
      end else begin
         timer <= timer + 32'd1;
      end
   end

   assign bus.inst_sram_rdata = inst_rdata_q;
   assign bus.data_sram_rdata = data_rdata_q;

   // Inputs the responder deliberately ignores.
   logic unused_bits;
   assign unused_bits = ^{bus.inst_sram_wen, bus.inst_sram_wdata,
                          bus.inst_sram_addr[31:ADDR_W+2],
                          bus.inst_sram_addr[1:0]};

endmodule

// File: tb/tb_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_sram_responder
// Directed self-checking bench for sram_responder: reset values, byte-lane
// writes, read latency/hold, read-first collision, timer load/wrap/partial
// load, reset mid-stream and ignored instruction-port writes.
// -----------------------------------------------------------------------------
module tb_sram_responder;

   localparam logic [31:0] TADDR = 32'hBFAF_E000;

   logic clk = 1'b0;
   logic rst;
   int   compared   = 0;
   int   mismatched = 0;

   always #5 clk = ~clk;

   sram_responder_if bus ();

   sram_responder #(
      .ADDR_W     (14),
      .TIMER_ADDR (TADDR)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_idle;
      bus.inst_sram_en    = 1'b0;
      bus.inst_sram_wen   = 4'h0;
      bus.inst_sram_addr  = '0;
      bus.inst_sram_wdata = '0;
      bus.data_sram_en    = 1'b0;
      bus.data_sram_wen   = 4'h0;
      bus.data_sram_addr  = '0;
      bus.data_sram_wdata = '0;
   endtask

   task automatic data_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
      set_idle();
      bus.data_sram_en    = 1'b1;
      bus.data_sram_wen   = w;
      bus.data_sram_addr  = a;
      bus.data_sram_wdata = d;
      tick();
      set_idle();
   endtask

   task automatic data_rd(input logic [31:0] a);
      set_idle();
      bus.data_sram_en   = 1'b1;
      bus.data_sram_addr = a;
      tick();
      set_idle();
   endtask

   task automatic inst_rd(input logic [31:0] a);
      set_idle();
      bus.inst_sram_en   = 1'b1;
      bus.inst_sram_addr = a;
      tick();
      set_idle();
   endtask

   initial begin
      set_idle();
      rst = 1'b1;

      // Reset
      tick();
      chk("rst_inst_0", bus.inst_sram_rdata, 32'h0);
      chk("rst_data_0", bus.data_sram_rdata, 32'h0);
      tick();
      rst = 1'b0;
      chk("rst_inst_1", bus.inst_sram_rdata, 32'h0);
      chk("rst_data_1", bus.data_sram_rdata, 32'h0);

      // Byte-lane writes, then back-to-back read
      data_wr(32'h0000_0010, 32'h1122_3344, 4'hF);
      chk("wr_no_rdata", bus.data_sram_rdata, 32'h0);
      data_wr(32'h0000_0010, 32'h0000_AA00, 4'b0010);
      data_rd(32'h0000_0010);
      chk("byte_merge", bus.data_sram_rdata, 32'h1122_AA44);

      // Read latency and hold
      data_wr(32'h0000_0020, 32'hDEAD_BEEF, 4'hF);
      inst_rd(32'h0000_0020);
      chk("inst_lat1", bus.inst_sram_rdata, 32'hDEAD_BEEF);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("inst_hold", bus.inst_sram_rdata, 32'hDEAD_BEEF);
      end
      chk("data_hold", bus.data_sram_rdata, 32'h1122_AA44);

      // Read-first collision
      data_wr(32'h0000_0040, 32'h0000_0001, 4'hF);
      set_idle();
      bus.inst_sram_en    = 1'b1;
      bus.inst_sram_addr  = 32'h0000_0040;
      bus.data_sram_en    = 1'b1;
      bus.data_sram_wen   = 4'hF;
      bus.data_sram_addr  = 32'h0000_0040;
      bus.data_sram_wdata = 32'h0000_0002;
      tick();
      set_idle();
      chk("coll_old", bus.inst_sram_rdata, 32'h0000_0001);
      inst_rd(32'h0000_0040);
      chk("coll_new_i", bus.inst_sram_rdata, 32'h0000_0002);
      data_rd(32'h0000_0040);
      chk("coll_new_d", bus.data_sram_rdata, 32'h0000_0002);

      // Timer load, wrap, partial load; aliased RAM word untouched
      data_wr(32'h0000_E000, 32'hCAFE_F00D, 4'hF);
      data_wr(TADDR, 32'hFFFF_FFFE, 4'hF);
      data_rd(TADDR);
      chk("tmr_0", bus.data_sram_rdata, 32'hFFFF_FFFE);
      data_rd(TADDR);
      chk("tmr_1", bus.data_sram_rdata, 32'hFFFF_FFFF);
      data_rd(TADDR);
      chk("tmr_wrap", bus.data_sram_rdata, 32'h0000_0000);
      data_rd(TADDR);
      chk("tmr_3", bus.data_sram_rdata, 32'h0000_0001);
      data_wr(TADDR, 32'h5A00_0000, 4'b1000);
      data_rd(TADDR);
      chk("tmr_part", bus.data_sram_rdata, 32'h5A00_0002);
      data_rd(32'h0000_E000);
      chk("tmr_alias", bus.data_sram_rdata, 32'hCAFE_F00D);

      // Address decode: low bits ignored, upper bits alias
      data_rd(32'h0000_0013);
      chk("addr_lo", bus.data_sram_rdata, 32'h1122_AA44);
      data_rd(32'h0001_0010);
      chk("addr_hi", bus.data_sram_rdata, 32'h1122_AA44);

      // Reset mid-stream: read, then reset with accesses that must be dropped
      data_rd(32'h0000_0020);
      chk("pre_rst", bus.data_sram_rdata, 32'hDEAD_BEEF);
      set_idle();
      rst = 1'b1;
      bus.inst_sram_en    = 1'b1;
      bus.inst_sram_addr  = 32'h0000_0020;
      bus.data_sram_en    = 1'b1;
      bus.data_sram_wen   = 4'hF;
      bus.data_sram_addr  = 32'h0000_0020;
      bus.data_sram_wdata = 32'h0000_0000;
      tick();
      set_idle();
      rst = 1'b0;
      chk("mid_rst_d", bus.data_sram_rdata, 32'h0);
      chk("mid_rst_i", bus.inst_sram_rdata, 32'h0);
      data_rd(TADDR);
      chk("tmr_rst", bus.data_sram_rdata, 32'h0);
      data_rd(32'h0000_0020);
      chk("rst_drop_wr", bus.data_sram_rdata, 32'hDEAD_BEEF);

      // Instruction-port write attempt is treated as a read
      set_idle();
      bus.inst_sram_en    = 1'b1;
      bus.inst_sram_wen   = 4'hF;
      bus.inst_sram_addr  = 32'h0000_0020;
      bus.inst_sram_wdata = 32'h1234_5678;
      tick();
      set_idle();
      chk("iwr_rd", bus.inst_sram_rdata, 32'hDEAD_BEEF);
      data_rd(32'h0000_0020);
      chk("iwr_ign", bus.data_sram_rdata, 32'hDEAD_BEEF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
